// File: rtl/ad1868_pkg.sv
// Shared constants and TX state encoding for the I2S to AD1868 playback path.
package ad1868_pkg;
  localparam int DATA_W_DEF = 18;
  localparam int AD_DIV_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } tx_state_t;
endpackage

// File: rtl/i2s_slot_capture.sv
// I2S receive front end: synchronizers, bclk edge detect and slot capture into
// left/right hold registers, flagging each completed L/R pair.
module i2s_slot_capture import ad1868_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_bclk,
  input  logic              i_lrck,
  input  logic              i_data,
  output logic [DATA_W-1:0] o_hold_l,
  output logic [DATA_W-1:0] o_hold_r,
  output logic              o_pair_ready
);
  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [1:0]        r_bclk_sync, r_lrck_sync, r_data_sync;
  logic              r_bclk_prev, r_bclk_rise, r_lrck_d, r_data_d;
  logic              r_seen, r_slot_valid, r_have_l, r_lr_prev, r_pair_ready;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_shift, r_hold_l, r_hold_r;
  logic [DATA_W-1:0] w_word;

  // Left-justify a slot shorter than DATA_W so missing LSBs read as zero.
  function automatic logic [DATA_W-1:0] pad_word(input logic [DATA_W-1:0] s,
                                                 input logic [CNT_W-1:0]  n);
    pad_word = s << (CNT_W'(DATA_W) - n);
  endfunction

  assign w_word = pad_word(r_shift, r_cnt);

  // Sync stage: lrck/data get one extra flop so they stay aligned with bclk_rise.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bclk_sync <= '0;
      r_lrck_sync <= '0;
      r_data_sync <= '0;
      r_bclk_prev <= 1'b0;
      r_bclk_rise <= 1'b0;
      r_lrck_d    <= 1'b0;
      r_data_d    <= 1'b0;
    end else begin
      r_bclk_sync <= {r_bclk_sync[0], i_bclk};
      r_lrck_sync <= {r_lrck_sync[0], i_lrck};
      r_data_sync <= {r_data_sync[0], i_data};
      r_bclk_prev <= r_bclk_sync[1];
      r_bclk_rise <= r_bclk_sync[1] & ~r_bclk_prev;
      r_lrck_d    <= r_lrck_sync[1];
      r_data_d    <= r_data_sync[1];
    end
  end

  // Slot stage: a pair is only announced when a left slot preceded the right one.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_seen       <= 1'b0;
      r_slot_valid <= 1'b0;
      r_have_l     <= 1'b0;
      r_lr_prev    <= 1'b0;
      r_pair_ready <= 1'b0;
      r_cnt        <= '0;
      r_shift      <= '0;
      r_hold_l     <= '0;
      r_hold_r     <= '0;
    end else begin
      r_pair_ready <= 1'b0;
      if (r_bclk_rise) begin
        r_lr_prev <= r_lrck_d;
        r_seen    <= 1'b1;
        if (r_seen && (r_lrck_d != r_lr_prev)) begin
          if (r_slot_valid) begin
            if (!r_lr_prev) begin
              r_hold_l <= w_word;
              r_have_l <= 1'b1;
            end else begin
              r_hold_r     <= w_word;
              r_have_l     <= 1'b0;
              r_pair_ready <= r_have_l;
            end
          end
          r_slot_valid <= 1'b1;
          r_cnt        <= '0;
          r_shift      <= '0;
        end else if (r_cnt < CNT_W'(DATA_W)) begin
          r_shift <= {r_shift[DATA_W-2:0], r_data_d};
          r_cnt   <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign o_hold_l     = r_hold_l;
  assign o_hold_r     = r_hold_r;
  assign o_pair_ready = r_pair_ready;
endmodule

// File: rtl/i2s_to_ad1868.sv
// I2S stereo input to AD1868 serial DAC output: pending pair buffer, bit-clock
// divider and shift/latch FSM, all in the mclk domain with registered outputs.
module i2s_to_ad1868 import ad1868_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int AD_DIV = AD_DIV_DEF
) (
  input  logic i_i2s_mclk,
  input  logic i_rst,
  input  logic i_i2s_bclk,
  input  logic i_i2s_lrck,
  input  logic i_i2s_data,
  output logic o_ad_clk,
  output logic o_ad_data_l,
  output logic o_ad_data_r,
  output logic o_ad_latch,
  output logic o_overrun
);
  localparam int HALF  = AD_DIV / 2;
  localparam int DIV_W = $clog2(AD_DIV + 1);
  localparam int BIT_W = $clog2(DATA_W);

  logic [DATA_W-1:0] w_hold_l, w_hold_r;
  logic              w_pair_ready, w_consume;
  logic [DATA_W-1:0] r_pend_l, r_pend_r, r_sh_l, r_sh_r;
  logic              r_pending, r_overrun;
  tx_state_t         r_state;
  logic [DIV_W-1:0]  r_div;
  logic [BIT_W-1:0]  r_bit;
  logic              r_ad_clk, r_data_l, r_data_r, r_latch;

  i2s_slot_capture #(.DATA_W(DATA_W)) u_cap (
    .i_clk       (i_i2s_mclk),
    .i_rst       (i_rst),
    .i_bclk      (i_i2s_bclk),
    .i_lrck      (i_i2s_lrck),
    .i_data      (i_i2s_data),
    .o_hold_l    (w_hold_l),
    .o_hold_r    (w_hold_r),
    .o_pair_ready(w_pair_ready)
  );

  assign w_consume = (r_state == ST_IDLE) && r_pending;

  // Pending stage: a pair arriving while IDLE consumes the old one is not an overrun.
  always_ff @(posedge i_i2s_mclk) begin
    if (i_rst) begin
      r_pend_l  <= '0;
      r_pend_r  <= '0;
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_pair_ready && r_pending && !w_consume;
      if (w_pair_ready) begin
        r_pend_l  <= w_hold_l;
        r_pend_r  <= w_hold_r;
        r_pending <= 1'b1;
      end else if (w_consume) begin
        r_pending <= 1'b0;
      end
    end
  end

  // TX stage: data only moves on the edge that drops o_ad_clk.
  always_ff @(posedge i_i2s_mclk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_div    <= '0;
      r_bit    <= '0;
      r_sh_l   <= '0;
      r_sh_r   <= '0;
      r_ad_clk <= 1'b0;
      r_data_l <= 1'b0;
      r_data_r <= 1'b0;
      r_latch  <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ad_clk <= 1'b0;
          r_latch  <= 1'b1;
          if (r_pending) begin
            r_sh_l   <= {r_pend_l[DATA_W-2:0], 1'b0};
            r_sh_r   <= {r_pend_r[DATA_W-2:0], 1'b0};
            r_data_l <= r_pend_l[DATA_W-1];
            r_data_r <= r_pend_r[DATA_W-1];
            r_div    <= '0;
            r_bit    <= '0;
            r_state  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (r_div == DIV_W'(AD_DIV - 1)) begin
            r_div    <= '0;
            r_ad_clk <= 1'b0;
            if (r_bit == BIT_W'(DATA_W - 1)) begin
              r_state <= ST_LATCH;
            end else begin
              r_bit    <= r_bit + 1'b1;
              r_data_l <= r_sh_l[DATA_W-1];
              r_data_r <= r_sh_r[DATA_W-1];
              r_sh_l   <= {r_sh_l[DATA_W-2:0], 1'b0};
              r_sh_r   <= {r_sh_r[DATA_W-2:0], 1'b0};
            end
          end else begin
            r_div <= r_div + 1'b1;
            if (r_div == DIV_W'(HALF - 1)) r_ad_clk <= 1'b1;
          end
        end
        ST_LATCH: begin
          if (r_div == DIV_W'(AD_DIV)) begin
            r_latch <= 1'b1;
            r_div   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_latch <= 1'b0;
            r_div   <= r_div + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_ad_clk    = r_ad_clk;
  assign o_ad_data_l = r_data_l;
  assign o_ad_data_r = r_data_r;
  assign o_ad_latch  = r_latch;
  assign o_overrun   = r_overrun;
endmodule

// File: tb/tb_i2s_to_ad1868.sv
// Bench for i2s_to_ad1868: drives I2S slots, decodes the AD1868 lines and
// compares received pairs with a slot-level reference model and fixed vectors.
module tb_i2s_to_ad1868;
  localparam int DW  = 18;
  localparam int DIV = 16;

  logic clk = 1'b0, rst = 1'b1, bclk = 1'b0, lrck = 1'b0, sdata = 1'b0;
  logic ad_clk, ad_dl, ad_dr, ad_latch, ovr;

  always #5 clk = ~clk;

  i2s_to_ad1868 dut (
    .i_i2s_mclk (clk),
    .i_rst      (rst),
    .i_i2s_bclk (bclk),
    .i_i2s_lrck (lrck),
    .i_i2s_data (sdata),
    .o_ad_clk   (ad_clk),
    .o_ad_data_l(ad_dl),
    .o_ad_data_r(ad_dr),
    .o_ad_latch (ad_latch),
    .o_overrun  (ovr)
  );

  typedef struct packed { logic [DW-1:0] l; logic [DW-1:0] r; } pair_t;
  typedef struct { logic [31:0] ls; logic [31:0] rs; int sw; int len; logic [DW-1:0] el; logic [DW-1:0] er; } vec_t;

  int n_tests = 0, n_fail = 0;
  pair_t rx_q[$], exp_q[$];

  // reference model state: bits of the slot being driven, and pair assembly
  logic p_bits[$];
  logic p_lr = 1'b0, p_valid = 1'b0, m_first = 1'b1, m_have_l = 1'b0;
  logic [DW-1:0] m_l = '0;

  // output decoder state
  int mon_nbits = 0, mon_rises = 0, mon_falls = 0, mon_ovr = 0, mon_viol = 0, low_len = 0;
  logic [DW-1:0] acc_l = '0, acc_r = '0;
  logic p_clk = 1'b0, p_latch = 1'b1, p_dl = 1'b0, p_dr = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      mon_nbits = 0;
    end else begin
      if (ad_clk && !p_clk) begin
        acc_l = {acc_l[DW-2:0], ad_dl};
        acc_r = {acc_r[DW-2:0], ad_dr};
        mon_nbits++;
        mon_rises++;
      end
      if (ad_clk && p_clk && (ad_dl !== p_dl || ad_dr !== p_dr)) mon_viol++;
      if (!ad_latch && p_latch) begin
        mon_falls++;
        low_len = 0;
        check("ad_clk_rises_per_pair", 64'(mon_nbits), 64'(DW));
        rx_q.push_back({acc_l, acc_r});
        mon_nbits = 0;
      end
      if (!ad_latch) low_len++;
      if (ad_latch && !p_latch) check("latch_low_cycles", 64'(low_len), 64'(DIV));
      if (ovr) mon_ovr++;
    end
    p_clk = ad_clk; p_latch = ad_latch; p_dl = ad_dl; p_dr = ad_dr;
  end

  // A slot is complete once the next slot's first bclk rise is driven.
  task automatic finalize_slot();
    logic [DW-1:0] w;
    w = '0;
    for (int k = 0; k < DW; k++) if (k < p_bits.size()) w[DW-1-k] = p_bits[k];
    if (m_first) m_first = 1'b0;
    else if (!p_lr) begin m_l = w; m_have_l = 1'b1; end
    else if (m_have_l) begin exp_q.push_back({m_l, w}); m_have_l = 1'b0; end
  endtask

  // First rise of a slot carries the previous word's LSB; sample bits follow MSB-first.
  task automatic drive_slot(input logic lr, input logic [31:0] sample, input int sw, input int len, input int half);
    logic b;
    if (p_valid) finalize_slot();
    p_bits.delete();
    p_lr = lr;
    p_valid = 1'b1;
    for (int i = 0; i < len; i++) begin
      b = (i >= 1 && i <= sw) ? sample[sw-i] : 1'($urandom_range(0, 1));
      bclk = 1'b0; lrck = lr; sdata = b;
      repeat (half) tick();
      bclk = 1'b1;
      repeat (half) tick();
      if (i >= 1) p_bits.push_back(b);
    end
  endtask

  task automatic reset_model();
    rx_q.delete(); exp_q.delete(); p_bits.delete();
    p_valid = 1'b0; m_first = 1'b1; m_have_l = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; bclk = 1'b0; lrck = 1'b0; sdata = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    reset_model();
    tick();
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < 4000 && rx_q.size() < n; k++) tick();
    repeat (40) tick();
  endtask

  task automatic cmp_pair(input string name, input int idx, input pair_t exp);
    pair_t got;
    got = (idx < rx_q.size()) ? rx_q[idx] : '0;
    check({name, "_l"}, 64'(got.l), 64'(exp.l));
    check({name, "_r"}, 64'(got.r), 64'(exp.r));
  endtask

  initial begin
    #800000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tv[6];
    int falls0, ovr0, h, len;
    logic [31:0] a, b;
    tv[0] = '{32'h2AAAA << 13, 32'h15555 << 13, 31, 32, 18'h2AAAA, 18'h15555};
    tv[1] = '{32'h2AAAA << 13, 32'h15555 << 13, 31, 32, 18'h2AAAA, 18'h15555};
    tv[2] = '{32'h0000FFFF, 32'h00008001, 16, 17, 18'h3FFFC, 18'h20004};
    tv[3] = '{32'h00ABCDEF, 32'h00123456, 24, 25, 18'h2AF37, 18'h048D1};
    tv[4] = '{32'h0003FFFF, 32'h00000000, 18, 19, 18'h3FFFF, 18'h00000};
    tv[5] = '{32'h00000001, 32'h00020000, 18, 19, 18'h00001, 18'h20000};

    // reset with random inputs toggling
    rst = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      bclk = 1'($urandom_range(0, 1)); lrck = 1'($urandom_range(0, 1)); sdata = 1'($urandom_range(0, 1));
      tick();
      @(negedge clk);
      check("reset_outputs", 64'({ad_clk, ad_dl, ad_dr, ad_latch, ovr}), 64'(5'b00010));
    end
    bclk = 1'b0; lrck = 1'b0; sdata = 1'b0;
    rst = 1'b0;
    reset_model();
    repeat (100) tick();
    check("no_ad_clk_before_pair", 64'(mon_rises), 64'd0);
    check("no_latch_before_pair", 64'(mon_falls), 64'd0);

    // table-driven frames, lead-in frame produces no output
    do_reset();
    ovr0 = mon_ovr;
    drive_slot(1'b0, tv[0].ls, tv[0].sw, tv[0].len, 4);
    drive_slot(1'b1, tv[0].rs, tv[0].sw, tv[0].len, 4);
    for (int i = 0; i < 6; i++) begin
      h = (tv[i].len < 26) ? 8 : 4;
      drive_slot(1'b0, tv[i].ls, tv[i].sw, tv[i].len, h);
      drive_slot(1'b1, tv[i].rs, tv[i].sw, tv[i].len, h);
    end
    drive_slot(1'b0, 32'd0, 0, 2, 4);
    drain(6);
    check("table_pair_count", 64'(rx_q.size()), 64'd6);
    for (int i = 0; i < 6; i++) cmp_pair($sformatf("table_%0d", i), i, {tv[i].el, tv[i].er});
    check("table_no_overrun", 64'(mon_ovr - ovr0), 64'd0);

    // start-up mid-left-slot
    do_reset();
    drive_slot(1'b0, $urandom, 31, 7, 4);
    drive_slot(1'b1, $urandom, 31, 32, 4);
    drive_slot(1'b0, 32'h12345 << 13, 31, 32, 4);
    drive_slot(1'b1, 32'h2FEDC << 13, 31, 32, 4);
    drive_slot(1'b0, 32'd0, 0, 2, 4);
    drain(1);
    check("startup_pair_count", 64'(rx_q.size()), 64'd1);
    cmp_pair("startup_first", 0, {18'h12345, 18'h2FEDC});

    // randomized frames against the reference model
    do_reset();
    drive_slot(1'b0, $urandom, 31, 32, 4);
    drive_slot(1'b1, $urandom, 31, 32, 4);
    for (int f = 0; f < 12; f++) begin
      len = $urandom_range(26, 32);
      drive_slot(1'b0, $urandom, len - 1, len, 4);
      drive_slot(1'b1, $urandom, len - 1, len, 4);
    end
    drive_slot(1'b0, 32'd0, 0, 2, 4);
    drain(12);
    check("random_pair_count", 64'(rx_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) cmp_pair($sformatf("random_%0d", i), i, exp_q[i]);

    // overrun: pairs 2 and 3 complete while pair 1 is still shifting
    do_reset();
    ovr0 = mon_ovr;
    a = 32'h1C3A5; b = 32'h0E1F2;
    drive_slot(1'b0, $urandom, 18, 19, 2);
    drive_slot(1'b1, $urandom, 18, 19, 2);
    drive_slot(1'b0, a, 18, 19, 2);
    drive_slot(1'b1, b, 18, 19, 2);
    drive_slot(1'b0, $urandom, 8, 9, 2);
    drive_slot(1'b1, $urandom, 8, 9, 2);
    drive_slot(1'b0, $urandom, 8, 9, 2);
    drive_slot(1'b1, $urandom, 8, 9, 2);
    drive_slot(1'b0, 32'd0, 0, 2, 2);
    drain(2);
    repeat (400) tick();
    check("overrun_pulses", 64'(mon_ovr - ovr0), 64'd1);
    check("overrun_tx_count", 64'(rx_q.size()), 64'd2);
    cmp_pair("overrun_first", 0, {a[DW-1:0], b[DW-1:0]});
    if (exp_q.size() == 3) cmp_pair("overrun_newest", 1, exp_q[2]);
    else check("overrun_model_pairs", 64'(exp_q.size()), 64'd3);

    // reset at bit 9 of SHIFT
    do_reset();
    falls0 = mon_falls;
    drive_slot(1'b0, $urandom, 31, 32, 4);
    drive_slot(1'b1, $urandom, 31, 32, 4);
    drive_slot(1'b0, 32'h1F0F0 << 13, 31, 32, 4);
    drive_slot(1'b1, 32'h0ABCD << 13, 31, 32, 4);
    drive_slot(1'b0, 32'd0, 0, 2, 4);
    for (int k = 0; k < 2000 && mon_nbits != 9; k++) tick();
    check("midop_reached_bit9", 64'(mon_nbits), 64'd9);
    rst = 1'b1; bclk = 1'b0; lrck = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("midop_reset_outputs", 64'({ad_clk, ad_dl, ad_dr, ad_latch, ovr}), 64'(5'b00010));
    rst = 1'b0;
    reset_model();
    repeat (400) tick();
    check("midop_no_latch", 64'(mon_falls - falls0), 64'd0);
    check("midop_no_pair", 64'(rx_q.size()), 64'd0);
    drive_slot(1'b0, $urandom, 31, 32, 4);
    drive_slot(1'b1, $urandom, 31, 32, 4);
    drive_slot(1'b0, 32'h2468A << 13, 31, 32, 4);
    drive_slot(1'b1, 32'h13579 << 13, 31, 32, 4);
    drive_slot(1'b0, 32'd0, 0, 2, 4);
    drain(1);
    check("midop_after_count", 64'(rx_q.size()), 64'd1);
    cmp_pair("midop_after", 0, {18'h2468A, 18'h13579});

    check("data_stable_while_clk_high", 64'(mon_viol), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
